// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg
// Shared constants for the arcade input mapper:
//   - 9-bit PS/2 scancodes ({extended, code}) for every mapped key
//   - bit indices inside the hps_io joystick words
//   - bit positions inside the active-low in0/in1 cabinet bytes
//   - coin pulse FSM state encoding
// No ports (package). Optional feature macro used by the mapper top:
// ARCADE_INPUT_AUTOFIRE_EN.

package arcade_input_pkg;

    // Arrow keys carry the extended prefix; the mapper ignores that bit for them.
    localparam logic [8:0] SC_UP    = 9'h175;
    localparam logic [8:0] SC_DOWN  = 9'h172;
    localparam logic [8:0] SC_LEFT  = 9'h16B;
    localparam logic [8:0] SC_RIGHT = 9'h174;

    localparam logic [8:0] SC_SPACE = 9'h029;
    localparam logic [8:0] SC_CTRL  = 9'h014;
    localparam logic [8:0] SC_F1    = 9'h005;
    localparam logic [8:0] SC_F2    = 9'h006;
    localparam logic [8:0] SC_F5    = 9'h003;
    localparam logic [8:0] SC_1     = 9'h016;
    localparam logic [8:0] SC_2     = 9'h01E;
    localparam logic [8:0] SC_5     = 9'h02E;
    localparam logic [8:0] SC_6     = 9'h036;
    localparam logic [8:0] SC_R     = 9'h02D;
    localparam logic [8:0] SC_F     = 9'h02B;
    localparam logic [8:0] SC_D     = 9'h023;
    localparam logic [8:0] SC_G     = 9'h034;
    localparam logic [8:0] SC_A     = 9'h01C;
    localparam logic [8:0] SC_S     = 9'h01B;

    // Joystick word layout (same for both players)
    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_FIRE   = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;
    localparam int JOY_SKIP   = 7;
    localparam int JOY_COIN   = 8;

    // in0 byte layout (bit 7 is unused and always reads inactive)
    localparam int IN0_UP1    = 0;
    localparam int IN0_LEFT1  = 1;
    localparam int IN0_RIGHT1 = 2;
    localparam int IN0_DOWN1  = 3;
    localparam int IN0_SKIP1  = 4;
    localparam int IN0_COIN1  = 5;
    localparam int IN0_COIN2  = 6;

    // in1 byte layout
    localparam int IN1_UP2    = 0;
    localparam int IN1_LEFT2  = 1;
    localparam int IN1_RIGHT2 = 2;
    localparam int IN1_DOWN2  = 3;
    localparam int IN1_FIRE1  = 4;
    localparam int IN1_START1 = 5;
    localparam int IN1_START2 = 6;
    localparam int IN1_FIRE2  = 7;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        HOLD
    } coin_state_t;

endpackage

// File: rtl/coin_pulse.sv
// coin_pulse
// Turns a level coin request into one fixed-length coin pulse lasting
// COIN_FRAMES frame ticks. Holding the request yields a single credit; the
// request must drop before another pulse can start.
// Ports:
//   clk_sys  in  system clock
//   reset_n  in  synchronous reset, active low
//   tick     in  one-cycle frame tick
//   req      in  coin request level (key or joystick)
//   inhibit  in  forces the FSM back to IDLE
//   coin     out coin asserted (active high) while pulsing

module coin_pulse
    import arcade_input_pkg::*;
#(
    parameter int COIN_FRAMES = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic tick,
    input  logic req,
    input  logic inhibit,
    output logic coin
);

    localparam logic [3:0] CNT_LAST = 4'(COIN_FRAMES - 1);

    coin_state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        req_d;

    // State, frame counter and request history. req_d keeps following the
    // request even while inhibited, so a coin held across a ROM download
    // does not look like a fresh press afterwards.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            req_d <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            req_d <= req;
        end
    end

    // Only a rising request edge starts a pulse; re-presses and releases
    // during PULSE/HOLD have no effect on the pulse length.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        coin      = 1'b0;
        case (state)
            IDLE: begin
                if (req && !req_d) begin
                    state_nxt = PULSE;
                    cnt_nxt   = 4'd0;
                end
            end
            PULSE: begin
                coin = 1'b1;
                if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = HOLD;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (!req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (inhibit) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper
// Merges PS/2 keyboard events and two hps_io joystick words into the
// registered, active-low cabinet bytes in0/in1 for the game core. Handles
// horizontal-display direction remapping and shapes coin requests into
// frame-counted pulses.
// Optional feature macro: ARCADE_INPUT_AUTOFIRE_EN (fire buttons toggle
// every AUTOFIRE_FRAMES frame ticks while held).
// Ports:
//   clk_sys     in  system clock
//   reset_n     in  synchronous reset, active low
//   ps2_key     in  [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   joystick_0  in  player 1 joystick word
//   joystick_1  in  player 2 joystick word
//   vblank      in  rising edge marks a frame tick
//   rotate      in  1 = horizontal display, remap directions
//   inhibit     in  1 = ROM download, force all inputs inactive
//   in0         out ~{0, coin2, coin1, skip1, down1, right1, left1, up1}
//   in1         out ~{fire2, start2, start1, fire1, down2, right2, left2, up2}

module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int COIN_FRAMES     = 4,
    parameter int AUTOFIRE_FRAMES = 3
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        vblank,
    input  logic        rotate,
    input  logic        inhibit,
    output logic [7:0]  in0,
    output logic [7:0]  in1
);

    logic       toggle_d;
    logic       vblank_d;
    logic       key_event;
    logic       tick;
    logic [8:0] key_code;

    logic key_up1, key_down1, key_left1, key_right1, key_fire1, key_skip1;
    logic key_up2, key_down2, key_left2, key_right2, key_fire2, key_skip2;
    logic key_start1, key_start2, key_coin1, key_coin2;

    logic up1_raw, down1_raw, left1_raw, right1_raw;
    logic up2_raw, down2_raw, left2_raw, right2_raw;
    logic up1, down1, left1, right1, up2, down2, left2, right2;
    logic fire1, fire2, fire1_out, fire2_out;
    logic start1, start2, skip1;
    logic coin1_req, coin2_req, coin1, coin2;
    logic [7:0] in0_act, in1_act;

    logic unused_bits;

    assign key_event = ps2_key[10] ^ toggle_d;
    assign key_code  = ps2_key[8:0];
    assign tick      = vblank & ~vblank_d;

    // Key capture: one register per logical input, written with the pressed
    // flag on the edge that sees the toggle change. Arrows match both with
    // and without the extended prefix.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            toggle_d   <= 1'b0;
            vblank_d   <= 1'b0;
            key_up1    <= 1'b0;
            key_down1  <= 1'b0;
            key_left1  <= 1'b0;
            key_right1 <= 1'b0;
            key_fire1  <= 1'b0;
            key_skip1  <= 1'b0;
            key_up2    <= 1'b0;
            key_down2  <= 1'b0;
            key_left2  <= 1'b0;
            key_right2 <= 1'b0;
            key_fire2  <= 1'b0;
            key_skip2  <= 1'b0;
            key_start1 <= 1'b0;
            key_start2 <= 1'b0;
            key_coin1  <= 1'b0;
            key_coin2  <= 1'b0;
        end else begin
            toggle_d <= ps2_key[10];
            vblank_d <= vblank;
            if (key_event) begin
                case (key_code)
                    SC_UP,    {1'b0, SC_UP[7:0]}:    key_up1    <= ps2_key[9];
                    SC_DOWN,  {1'b0, SC_DOWN[7:0]}:  key_down1  <= ps2_key[9];
                    SC_LEFT,  {1'b0, SC_LEFT[7:0]}:  key_left1  <= ps2_key[9];
                    SC_RIGHT, {1'b0, SC_RIGHT[7:0]}: key_right1 <= ps2_key[9];
                    SC_SPACE, SC_CTRL:               key_fire1  <= ps2_key[9];
                    SC_F1, SC_1:                     key_start1 <= ps2_key[9];
                    SC_F2, SC_2:                     key_start2 <= ps2_key[9];
                    SC_F5:                           key_skip1  <= ps2_key[9];
                    SC_5:                            key_coin1  <= ps2_key[9];
                    SC_6:                            key_coin2  <= ps2_key[9];
                    SC_R:                            key_up2    <= ps2_key[9];
                    SC_F:                            key_down2  <= ps2_key[9];
                    SC_D:                            key_left2  <= ps2_key[9];
                    SC_G:                            key_right2 <= ps2_key[9];
                    SC_A:                            key_fire2  <= ps2_key[9];
                    SC_S:                            key_skip2  <= ps2_key[9];
                    default: ;
                endcase
            end
        end
    end

    // Merge keyboard and joystick, then rotate directions for horizontal
    // mode. Start buttons are cabinet-wide, so either joystick can press them.
    always_comb begin
        up1_raw    = key_up1    | joystick_0[JOY_UP];
        down1_raw  = key_down1  | joystick_0[JOY_DOWN];
        left1_raw  = key_left1  | joystick_0[JOY_LEFT];
        right1_raw = key_right1 | joystick_0[JOY_RIGHT];
        up2_raw    = key_up2    | joystick_1[JOY_UP];
        down2_raw  = key_down2  | joystick_1[JOY_DOWN];
        left2_raw  = key_left2  | joystick_1[JOY_LEFT];
        right2_raw = key_right2 | joystick_1[JOY_RIGHT];
        fire1      = key_fire1  | joystick_0[JOY_FIRE];
        fire2      = key_fire2  | joystick_1[JOY_FIRE];
        skip1      = key_skip1  | joystick_0[JOY_SKIP];
        start1     = key_start1 | joystick_0[JOY_START1] | joystick_1[JOY_START1];
        start2     = key_start2 | joystick_0[JOY_START2] | joystick_1[JOY_START2];
        coin1_req  = key_coin1  | joystick_0[JOY_COIN];
        coin2_req  = key_coin2  | joystick_1[JOY_COIN];
        if (rotate) begin
            up1    = left1_raw;
            down1  = right1_raw;
            left1  = down1_raw;
            right1 = up1_raw;
            up2    = left2_raw;
            down2  = right2_raw;
            left2  = down2_raw;
            right2 = up2_raw;
        end else begin
            up1    = up1_raw;
            down1  = down1_raw;
            left1  = left1_raw;
            right1 = right1_raw;
            up2    = up2_raw;
            down2  = down2_raw;
            left2  = left2_raw;
            right2 = right2_raw;
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam logic [3:0] AF_LAST = 4'(AUTOFIRE_FRAMES - 1);

    logic [3:0] af_cnt1, af_cnt2;
    logic       af_phase1, af_phase2;

    // Autofire phase: starts in the asserted phase on press and flips every
    // AUTOFIRE_FRAMES ticks; releasing fire or inhibiting restarts it.
    always_ff @(posedge clk_sys) begin
        if (!reset_n || inhibit || !fire1) begin
            af_cnt1   <= 4'd0;
            af_phase1 <= 1'b0;
        end else if (tick) begin
            if (af_cnt1 == AF_LAST) begin
                af_cnt1   <= 4'd0;
                af_phase1 <= ~af_phase1;
            end else begin
                af_cnt1 <= af_cnt1 + 4'd1;
            end
        end
    end

    // Same autofire timing for player 2 fire.
    always_ff @(posedge clk_sys) begin
        if (!reset_n || inhibit || !fire2) begin
            af_cnt2   <= 4'd0;
            af_phase2 <= 1'b0;
        end else if (tick) begin
            if (af_cnt2 == AF_LAST) begin
                af_cnt2   <= 4'd0;
                af_phase2 <= ~af_phase2;
            end else begin
                af_cnt2 <= af_cnt2 + 4'd1;
            end
        end
    end

    assign fire1_out = fire1 & ~af_phase1;
    assign fire2_out = fire2 & ~af_phase2;
`else
    localparam int unused_autofire_frames = AUTOFIRE_FRAMES;

    assign fire1_out = fire1;
    assign fire2_out = fire2;
`endif

    coin_pulse #(.COIN_FRAMES(COIN_FRAMES)) u_coin1 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .tick    (tick),
        .req     (coin1_req),
        .inhibit (inhibit),
        .coin    (coin1)
    );

    coin_pulse #(.COIN_FRAMES(COIN_FRAMES)) u_coin2 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .tick    (tick),
        .req     (coin2_req),
        .inhibit (inhibit),
        .coin    (coin2)
    );

    // Assemble active-high views of the two cabinet bytes.
    always_comb begin
        in0_act             = 8'h00;
        in0_act[IN0_UP1]    = up1;
        in0_act[IN0_LEFT1]  = left1;
        in0_act[IN0_RIGHT1] = right1;
        in0_act[IN0_DOWN1]  = down1;
        in0_act[IN0_SKIP1]  = skip1;
        in0_act[IN0_COIN1]  = coin1;
        in0_act[IN0_COIN2]  = coin2;

        in1_act             = 8'h00;
        in1_act[IN1_UP2]    = up2;
        in1_act[IN1_LEFT2]  = left2;
        in1_act[IN1_RIGHT2] = right2;
        in1_act[IN1_DOWN2]  = down2;
        in1_act[IN1_FIRE1]  = fire1_out;
        in1_act[IN1_START1] = start1;
        in1_act[IN1_START2] = start2;
        in1_act[IN1_FIRE2]  = fire2_out;
    end

    // Registered active-low outputs; inhibit blanks everything on the next edge.
    always_ff @(posedge clk_sys) begin
        if (!reset_n || inhibit) begin
            in0 <= 8'hFF;
            in1 <= 8'hFF;
        end else begin
            in0 <= ~in0_act;
            in1 <= ~in1_act;
        end
    end

    // Inputs with no cabinet destination (upper joystick bits, P2 skip).
    assign unused_bits = ^{joystick_0[15:9], joystick_1[15:9],
                           joystick_1[JOY_SKIP], key_skip2};

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper
// Self-checking bench for arcade_input_mapper: directed scenarios plus a
// randomized key/joystick/rotate sequence compared with a behavioural model
// of the cabinet bytes. Autofire scenario is compiled only with
// ARCADE_INPUT_AUTOFIRE_EN.

module tb_arcade_input_mapper;

    localparam int COIN_FRAMES     = 4;
    localparam int AUTOFIRE_FRAMES = 3;
    localparam int FRAME_CYCLES    = 8;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        vblank;
    logic        rotate;
    logic        inhibit;
    logic [7:0]  in0;
    logic [7:0]  in1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic tog = 1'b0;

    // Logical key state as last reported by the keyboard:
    // 0 up1 1 down1 2 left1 3 right1 4 fire1 5 start1 6 start2 7 skip1
    // 8 coin1 9 coin2 10 up2 11 down2 12 left2 13 right2 14 fire2 15 skip2
    bit kst [16];

    // Scancodes used by the random sequence and the logical key they drive
    // (-1 = not a mapped key). Coin keys are left out on purpose.
    logic [8:0] code_tab [0:20] = '{
        9'h175, 9'h075, 9'h172, 9'h072, 9'h16B, 9'h174, 9'h029, 9'h014,
        9'h005, 9'h016, 9'h006, 9'h01E, 9'h003, 9'h02D, 9'h02B, 9'h023,
        9'h034, 9'h01C, 9'h01B, 9'h11C, 9'h01A
    };
    int idx_tab [0:20] = '{
        0, 0, 1, 1, 2, 3, 4, 4,
        5, 5, 6, 6, 7, 10, 11, 12,
        13, 14, 15, -1, -1
    };

    arcade_input_mapper #(
        .COIN_FRAMES     (COIN_FRAMES),
        .AUTOFIRE_FRAMES (AUTOFIRE_FRAMES)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .vblank     (vblank),
        .rotate     (rotate),
        .inhibit    (inhibit),
        .in0        (in0),
        .in1        (in1)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference view of {in1, in0} with no coin activity and no ticks,
    // built from the mapping rules: key OR joystick, then rotation.
    function automatic logic [15:0] model_out(input logic [15:0] j0,
                                              input logic [15:0] j1,
                                              input logic rot);
        bit u1, d1, l1, r1, u2, d2, l2, r2;
        bit f1, f2, s1, s2, sk1;
        logic [7:0] e0, e1;
        u1 = kst[0] | j0[3];
        d1 = kst[1] | j0[2];
        l1 = kst[2] | j0[1];
        r1 = kst[3] | j0[0];
        u2 = kst[10] | j1[3];
        d2 = kst[11] | j1[2];
        l2 = kst[12] | j1[1];
        r2 = kst[13] | j1[0];
        f1 = kst[4] | j0[4];
        f2 = kst[14] | j1[4];
        s1 = kst[5] | j0[5] | j1[5];
        s2 = kst[6] | j0[6] | j1[6];
        sk1 = kst[7] | j0[7];
        if (rot) begin
            {u1, d1, l1, r1} = {l1, r1, d1, u1};
            {u2, d2, l2, r2} = {l2, r2, d2, u2};
        end
        e0 = ~{1'b0, 1'b0, 1'b0, sk1, d1, r1, l1, u1};
        e1 = ~{f2, s2, s1, f1, d2, r2, l2, u2};
        return {e1, e0};
    endfunction

    // Issue one keyboard event (called at a falling edge).
    task automatic send_key(input logic [8:0] code, input logic pressed);
        tog = ~tog;
        ps2_key = {tog, pressed, code};
    endtask

    // One frame: vblank rises for one cycle, then stays low.
    task automatic run_frame();
        vblank = 1'b1;
        @(negedge clk_sys);
        vblank = 1'b0;
        repeat (FRAME_CYCLES - 1) @(negedge clk_sys);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        ps2_key    = 11'h000;
        tog        = 1'b0;
        joystick_0 = 16'h0000;
        joystick_1 = 16'h0000;
        vblank     = 1'b0;
        rotate     = 1'b0;
        inhibit    = 1'b0;
        foreach (kst[i]) kst[i] = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({in1, in0} !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL reset_out: got %h required %h", {in1, in0}, 16'hFFFF);
        end
    endtask

    task automatic test_key_arrow();
        send_key(9'h175, 1'b1);
        @(negedge clk_sys);
        tests_run++;
        if (in0 !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL key_latency1: got %h required %h", in0, 8'hFF);
        end
        @(negedge clk_sys);
        tests_run++;
        if (in0 !== 8'hFE) begin
            tests_failed++;
            $display("[TB] FAIL key_up_press: got %h required %h", in0, 8'hFE);
        end
        send_key(9'h175, 1'b0);
        repeat (2) @(negedge clk_sys);
        tests_run++;
        if (in0 !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL key_up_release: got %h required %h", in0, 8'hFF);
        end
    endtask

    task automatic test_rotate();
        rotate     = 1'b1;
        joystick_0 = 16'h0002;
        @(negedge clk_sys);
        tests_run++;
        if (in0 !== 8'hFE) begin
            tests_failed++;
            $display("[TB] FAIL rotate_on: got %h required %h", in0, 8'hFE);
        end
        rotate = 1'b0;
        @(negedge clk_sys);
        tests_run++;
        if (in0 !== 8'hFD) begin
            tests_failed++;
            $display("[TB] FAIL rotate_off: got %h required %h", in0, 8'hFD);
        end
        joystick_0 = 16'h0000;
        @(negedge clk_sys);
    endtask

    task automatic test_back_to_back();
        send_key(9'h175, 1'b1);
        @(negedge clk_sys);
        send_key(9'h174, 1'b1);
        repeat (2) @(negedge clk_sys);
        tests_run++;
        if (in0 !== 8'hFA) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back: got %h required %h", in0, 8'hFA);
        end
        send_key(9'h175, 1'b0);
        @(negedge clk_sys);
        send_key(9'h174, 1'b0);
        repeat (2) @(negedge clk_sys);
        tests_run++;
        if (in0 !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_rel: got %h required %h", in0, 8'hFF);
        end
    endtask

    task automatic test_random();
        int act;
        int k;
        logic p;
        logic [15:0] exp_out;
        for (int it = 0; it < 40; it++) begin
            act = $urandom_range(0, 3);
            case (act)
                0, 1: begin
                    k = $urandom_range(0, 20);
                    p = 1'($urandom_range(0, 1));
                    send_key(code_tab[k], p);
                    if (idx_tab[k] >= 0) kst[idx_tab[k]] = p;
                end
                2: begin
                    joystick_0 = 16'($urandom) & 16'h00FF;
                    joystick_1 = 16'($urandom) & 16'h00FF;
                end
                default: rotate = ~rotate;
            endcase
            repeat (2) @(negedge clk_sys);
            exp_out = model_out(joystick_0, joystick_1, rotate);
            tests_run++;
            if ({in1, in0} !== exp_out) begin
                tests_failed++;
                $display("[TB] FAIL random_%0d: got %h required %h", it, {in1, in0}, exp_out);
            end
        end
    endtask

    task automatic test_coin_hold();
        logic [19:0] seen;
        logic [19:0] expect_pat;
        expect_pat = '0;
        for (int i = 0; i < 20; i++) expect_pat[i] = (i < COIN_FRAMES);
        send_key(9'h02E, 1'b1);
        repeat (3) @(negedge clk_sys);
        for (int f = 0; f < 20; f++) begin
            seen[f] = ~in0[5];
            run_frame();
        end
        tests_run++;
        if (seen !== expect_pat) begin
            tests_failed++;
            $display("[TB] FAIL coin_hold_pattern: got %b required %b", seen, expect_pat);
        end
        send_key(9'h02E, 1'b0);
        repeat (3) @(negedge clk_sys);
        send_key(9'h02E, 1'b1);
        repeat (3) @(negedge clk_sys);
        seen = '0;
        for (int f = 0; f < 8; f++) begin
            seen[f] = ~in0[5];
            run_frame();
        end
        tests_run++;
        if (seen[7:0] !== expect_pat[7:0]) begin
            tests_failed++;
            $display("[TB] FAIL coin_repress_pattern: got %b required %b", seen[7:0], expect_pat[7:0]);
        end
        send_key(9'h02E, 1'b0);
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic test_coin_both();
        logic [7:0] seen1, seen2, expect_pat;
        expect_pat = '0;
        for (int i = 0; i < 8; i++) expect_pat[i] = (i < COIN_FRAMES);
        joystick_0 = 16'h0100;
        joystick_1 = 16'h0100;
        repeat (2) @(negedge clk_sys);
        for (int f = 0; f < 8; f++) begin
            seen1[f] = ~in0[5];
            seen2[f] = ~in0[6];
            run_frame();
        end
        tests_run++;
        if (seen1 !== expect_pat) begin
            tests_failed++;
            $display("[TB] FAIL coin_both_c1: got %b required %b", seen1, expect_pat);
        end
        tests_run++;
        if (seen2 !== expect_pat) begin
            tests_failed++;
            $display("[TB] FAIL coin_both_c2: got %b required %b", seen2, expect_pat);
        end
        joystick_0 = 16'h0000;
        joystick_1 = 16'h0000;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_inhibit();
        logic [7:0] worst;
        inhibit    = 1'b1;
        joystick_0 = 16'h0100;
        joystick_1 = 16'h0010;
        repeat (2) @(negedge clk_sys);
        tests_run++;
        if ({in1, in0} !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL inhibit_blank: got %h required %h", {in1, in0}, 16'hFFFF);
        end
        inhibit = 1'b0;
        @(negedge clk_sys);
        tests_run++;
        if (in1 !== 8'h7F) begin
            tests_failed++;
            $display("[TB] FAIL inhibit_drop_in1: got %h required %h", in1, 8'h7F);
        end
        worst = 8'hFF;
        for (int f = 0; f < 6; f++) begin
            worst = worst & in0;
            run_frame();
        end
        tests_run++;
        if (worst !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL inhibit_no_coin: got %h required %h", worst, 8'hFF);
        end
        joystick_0 = 16'h0000;
        repeat (2) @(negedge clk_sys);
        joystick_0 = 16'h0100;
        repeat (2) @(negedge clk_sys);
        tests_run++;
        if (in0 !== 8'hDF) begin
            tests_failed++;
            $display("[TB] FAIL inhibit_repress: got %h required %h", in0, 8'hDF);
        end
    endtask

    task automatic test_reset_mid_pulse();
        reset_n    = 1'b0;
        joystick_0 = 16'h0000;
        joystick_1 = 16'h0000;
        @(negedge clk_sys);
        tests_run++;
        if ({in1, in0} !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_pulse: got %h required %h", {in1, in0}, 16'hFFFF);
        end
        reset_n = 1'b1;
        foreach (kst[i]) kst[i] = 1'b0;
        repeat (2) @(negedge clk_sys);
        tests_run++;
        if (in0 !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL after_reset_idle: got %h required %h", in0, 8'hFF);
        end
    endtask

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    task automatic test_autofire();
        logic [11:0] seen, expect_pat;
        for (int k = 0; k < 12; k++) expect_pat[k] = ((k / AUTOFIRE_FRAMES) % 2) == 0;
        send_key(9'h029, 1'b1);
        repeat (2) @(negedge clk_sys);
        for (int f = 0; f < 12; f++) begin
            seen[f] = ~in1[4];
            run_frame();
        end
        tests_run++;
        if (seen !== expect_pat) begin
            tests_failed++;
            $display("[TB] FAIL autofire_pattern: got %b required %b", seen, expect_pat);
        end
        send_key(9'h029, 1'b0);
        repeat (2) @(negedge clk_sys);
    endtask
`endif

    initial begin
        test_reset();
        test_key_arrow();
        test_rotate();
        test_back_to_back();
        test_random();
        do_reset();
        test_coin_hold();
        test_coin_both();
        test_inhibit();
        test_reset_mid_pulse();
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        test_autofire();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
